reorder_buffer_p: RTL and testbench

Parametrised reorder buffer: successor to the fixed 16-entry ROB. Sits between decode/dispatch and the RS/LSB/regfile. It allocates tags in program order and accepts results from multiple write-back ports. Source-operand lookups are answered with same-cycle bypass. Entries commit in order, one per cycle; stores commit via an LSB handshake, and mispredicted branches/JALR trigger a full flush with redirect PC.

---
 rtl/rob_pkg.sv | 29 ++
 rtl/rob_bypass.sv | 30 +++
 rtl/reorder_buffer_p.sv | 152 +++++++++++++++
 tb/tb_reorder_buffer_p.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types for the parametrised reorder buffer: instruction kinds and
// the per-entry control record.
package rob_pkg;

    localparam int ROB_XLEN = 32;

    typedef enum logic [1:0] {
        ROB_REG   = 2'd0,
        ROB_STORE = 2'd1,
        ROB_BR    = 2'd2,
        ROB_JALR  = 2'd3
    } rob_kind_e;

    // Wide datapath fields (pc, val, target) live in separate packed arrays
    // so XLEN can be overridden without touching this record.
    typedef struct packed {
        logic      busy;
        logic      ready;
        rob_kind_e kind;
        logic [4:0] rd;
        logic      pred_taken;
        logic      taken;
    } rob_ctrl_t;

    function automatic logic rob_mispredict(input rob_ctrl_t e);
        return (e.kind == ROB_JALR) || ((e.kind == ROB_BR) && (e.taken != e.pred_taken));
    endfunction

endpackage

// File: rtl/rob_bypass.sv
// One operand lookup port: stored entry state merged with the live
// write-back buses; the highest-numbered matching port supplies the value.
module rob_bypass #(
    parameter int DEPTH  = 16,
    parameter int NUM_WB = 2,
    parameter int XLEN   = 32,
    parameter int TAG_W  = 4
) (
    input  logic [TAG_W-1:0]            tag,
    input  logic [DEPTH-1:0]            ready,
    input  logic [DEPTH-1:0][XLEN-1:0]  val,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]     wb_tag,
    input  logic [NUM_WB*XLEN-1:0]      wb_val,
    output logic                        hit_ready,
    output logic [XLEN-1:0]             hit_val
);

    always_comb begin
        hit_ready = ready[tag];
        hit_val   = val[tag];
        for (int p = 0; p < NUM_WB; p++) begin
            if (wb_valid[p] && (wb_tag[p*TAG_W +: TAG_W] == tag)) begin
                hit_ready = 1'b1;
                hit_val   = wb_val[p*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/reorder_buffer_p.sv
// Parametrised reorder buffer: in-order allocation, multi-port write-back,
// bypassed operand lookup, in-order single commit with mispredict flush.
module reorder_buffer_p
    import rob_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int NUM_WB = 2,
    parameter  int XLEN   = ROB_XLEN,
    localparam int TAG_W  = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     disp_valid,
    output logic                     disp_ready,
    input  logic [1:0]               disp_kind,
    input  logic [4:0]               disp_rd,
    input  logic [XLEN-1:0]          disp_pc,
    input  logic                     disp_pred_taken,
    output logic [TAG_W-1:0]         disp_tag,
    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
    input  logic [NUM_WB*XLEN-1:0]   wb_val,
    input  logic [NUM_WB-1:0]        wb_taken,
    input  logic [NUM_WB*XLEN-1:0]   wb_target,
    input  logic [2*TAG_W-1:0]       q_tag,
    output logic [1:0]               q_ready,
    output logic [2*XLEN-1:0]        q_val,
    input  logic                     st_commit_ready,
    output logic                     cm_valid,
    output logic [TAG_W-1:0]         cm_tag,
    output logic [4:0]               cm_rd,
    output logic [XLEN-1:0]          cm_val,
    output logic                     cm_is_store,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc,
    output logic [TAG_W:0]           count
);

    rob_ctrl_t                 ctrl [DEPTH];
    logic [DEPTH-1:0][XLEN-1:0] pc_q;
    logic [DEPTH-1:0][XLEN-1:0] val_q;
    logic [DEPTH-1:0][XLEN-1:0] tgt_q;
    logic [DEPTH-1:0]          ready_vec;

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic [TAG_W:0]   cnt;
    logic             flush_q;
    logic [XLEN-1:0]  flush_pc_q;

    rob_ctrl_t head_e;
    logic      disp_fire;
    logic      commit;
    logic      mispredict;

    // Full-buffer check uses the registered count, so a commit in the same
    // cycle does not reopen dispatch until the next cycle.
    assign disp_ready = (cnt < (TAG_W+1)'(DEPTH)) && !flush_q;
    assign disp_tag   = tail;
    assign disp_fire  = disp_valid && disp_ready && rdy;

    assign head_e     = ctrl[head];
    assign commit     = rdy && head_e.busy && head_e.ready &&
                        ((head_e.kind != ROB_STORE) || st_commit_ready);
    assign mispredict = commit && rob_mispredict(head_e);

    assign cm_valid    = commit;
    assign cm_tag      = head;
    assign cm_rd       = head_e.rd;
    assign cm_is_store = (head_e.kind == ROB_STORE);
    assign cm_val      = (head_e.kind == ROB_JALR) ? pc_q[head] + XLEN'(4) : val_q[head];

    assign flush    = flush_q && rdy;
    assign flush_pc = flush_pc_q;
    assign count    = cnt;

    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < DEPTH; i++) ready_vec[i] = ctrl[i].ready;
    end

    for (genvar g = 0; g < 2; g++) begin : g_q
        rob_bypass #(
            .DEPTH(DEPTH), .NUM_WB(NUM_WB), .XLEN(XLEN), .TAG_W(TAG_W)
        ) u_bypass (
            .tag      (q_tag[g*TAG_W +: TAG_W]),
            .ready    (ready_vec),
            .val      (val_q),
            .wb_valid (wb_valid),
            .wb_tag   (wb_tag),
            .wb_val   (wb_val),
            .hit_ready(q_ready[g]),
            .hit_val  (q_val[g*XLEN +: XLEN])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            pc_q       <= '0;
            val_q      <= '0;
            tgt_q      <= '0;
            for (int i = 0; i < DEPTH; i++) ctrl[i] <= '0;
        end else if (rdy) begin
            flush_q <= mispredict;
            if (mispredict)
                flush_pc_q <= ((head_e.kind == ROB_JALR) || head_e.taken) ? tgt_q[head]
                                                                          : pc_q[head] + XLEN'(4);

            // Later ports overwrite earlier ones on a shared tag.
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && ctrl[wb_tag[p*TAG_W +: TAG_W]].busy) begin
                    ctrl[wb_tag[p*TAG_W +: TAG_W]].ready  <= 1'b1;
                    ctrl[wb_tag[p*TAG_W +: TAG_W]].taken  <= wb_taken[p];
                    val_q[wb_tag[p*TAG_W +: TAG_W]]       <= wb_val[p*XLEN +: XLEN];
                    tgt_q[wb_tag[p*TAG_W +: TAG_W]]       <= wb_target[p*XLEN +: XLEN];
                end
            end

            if (mispredict) begin
                head <= '0;
                tail <= '0;
                cnt  <= '0;
                for (int i = 0; i < DEPTH; i++) ctrl[i].busy <= 1'b0;
            end else begin
                if (commit) begin
                    ctrl[head].busy <= 1'b0;
                    head            <= head + TAG_W'(1);
                end
                if (disp_fire) begin
                    ctrl[tail] <= '{busy:       1'b1,
                                    ready:      (rob_kind_e'(disp_kind) == ROB_STORE),
                                    kind:       rob_kind_e'(disp_kind),
                                    rd:         disp_rd,
                                    pred_taken: disp_pred_taken,
                                    taken:      1'b0};
                    pc_q[tail]  <= disp_pc;
                    val_q[tail] <= '0;
                    tgt_q[tail] <= '0;
                    tail        <= tail + TAG_W'(1);
                end
                cnt <= cnt + (TAG_W+1)'(disp_fire) - (TAG_W+1)'(commit);
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer_p.sv
// Directed and randomized bench for reorder_buffer_p against an occupancy-window
// reference model of the buffer's program-order rules.
module tb_reorder_buffer_p;

    localparam int D  = 16;
    localparam int NW = 2;
    localparam int XL = 32;
    localparam int TW = 4;

    logic            clk = 1'b0;
    logic            rst, rdy, disp_valid, disp_pred_taken, disp_ready;
    logic [1:0]      disp_kind;
    logic [4:0]      disp_rd;
    logic [XL-1:0]   disp_pc;
    logic [TW-1:0]   disp_tag;
    logic [NW-1:0]   wb_valid, wb_taken;
    logic [NW*TW-1:0] wb_tag;
    logic [NW*XL-1:0] wb_val, wb_target;
    logic [2*TW-1:0] q_tag;
    logic [1:0]      q_ready;
    logic [2*XL-1:0] q_val;
    logic            st_commit_ready, cm_valid, cm_is_store, flush;
    logic [TW-1:0]   cm_tag;
    logic [4:0]      cm_rd;
    logic [XL-1:0]   cm_val, flush_pc;
    logic [TW:0]     count;

    reorder_buffer_p #(.DEPTH(D), .NUM_WB(NW), .XLEN(XL)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_kind(disp_kind),
        .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_pred_taken(disp_pred_taken),
        .disp_tag(disp_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val),
        .wb_taken(wb_taken), .wb_target(wb_target),
        .q_tag(q_tag), .q_ready(q_ready), .q_val(q_val),
        .st_commit_ready(st_commit_ready),
        .cm_valid(cm_valid), .cm_tag(cm_tag), .cm_rd(cm_rd), .cm_val(cm_val),
        .cm_is_store(cm_is_store), .flush(flush), .flush_pc(flush_pc), .count(count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int commit_log[$];

    // Reference state: occupied window [m_head, m_head+m_count) plus per-tag fields.
    int          m_head, m_count;
    logic        m_ready [D];
    int          m_kind  [D];
    logic [4:0]  m_rd    [D];
    logic [31:0] m_pc [D], m_val [D], m_tgt [D];
    logic        m_pred [D], m_taken [D];
    logic        m_flush;
    logic [31:0] m_fpc;
    logic        e_disp_ready, e_cm_valid;
    int          e_h;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_window(input int t);
        return ((t - m_head + D) % D) < m_count;
    endfunction

    task automatic model_reset();
        m_head = 0; m_count = 0; m_flush = 1'b0; m_fpc = '0;
        for (int i = 0; i < D; i++) begin
            m_ready[i] = 1'b0; m_kind[i] = 0; m_rd[i] = '0; m_pc[i] = '0;
            m_val[i] = '0; m_tgt[i] = '0; m_pred[i] = 1'b0; m_taken[i] = 1'b0;
        end
    endtask

    task automatic idle();
        rdy = 1'b1; disp_valid = 1'b0; disp_kind = 2'd0; disp_rd = '0; disp_pc = '0;
        disp_pred_taken = 1'b0; wb_valid = '0; wb_tag = '0; wb_val = '0; wb_taken = '0;
        wb_target = '0; q_tag = '0; st_commit_ready = 1'b1;
    endtask

    task automatic disp(input int kind, input int rd, input logic [31:0] pc, input logic pred);
        disp_valid = 1'b1; disp_kind = 2'(kind); disp_rd = 5'(rd); disp_pc = pc;
        disp_pred_taken = pred;
    endtask

    task automatic wb(input int p, input int tag, input logic [31:0] v, input logic tk,
                      input logic [31:0] tgt);
        wb_valid[p] = 1'b1; wb_tag[p*TW +: TW] = TW'(tag); wb_val[p*XL +: XL] = v;
        wb_taken[p] = tk; wb_target[p*XL +: XL] = tgt;
    endtask

    // Compare every output against the model just before the edge.
    task automatic settle();
        logic [TW-1:0] qt;
        logic          r;
        logic [31:0]   v;
        #1;
        e_disp_ready = (m_count < D) && !m_flush;
        chk("disp_ready", disp_ready, e_disp_ready);
        chk("count", count, m_count);
        chk("flush", flush, m_flush && rdy);
        chk("flush_pc", flush_pc, m_fpc);
        if (e_disp_ready) chk("disp_tag", disp_tag, (m_head + m_count) % D);
        for (int i = 0; i < 2; i++) begin
            qt = q_tag[i*TW +: TW];
            r = m_ready[qt]; v = m_val[qt];
            for (int p = 0; p < NW; p++)
                if (wb_valid[p] && wb_tag[p*TW +: TW] == qt) begin
                    r = 1'b1; v = wb_val[p*XL +: XL];
                end
            chk("q_ready", q_ready[i], r);
            chk("q_val", q_val[i*XL +: XL], v);
        end
        e_h = m_head;
        e_cm_valid = rdy && (m_count > 0) && m_ready[e_h] && (m_kind[e_h] != 1 || st_commit_ready);
        chk("cm_valid", cm_valid, e_cm_valid);
        if (e_cm_valid) begin
            chk("cm_tag", cm_tag, e_h);
            chk("cm_rd", cm_rd, m_rd[e_h]);
            chk("cm_is_store", cm_is_store, m_kind[e_h] == 1);
            chk("cm_val", cm_val, (m_kind[e_h] == 3) ? m_pc[e_h] + 32'd4 : m_val[e_h]);
            commit_log.push_back(int'(cm_tag));
        end
    endtask

    task automatic edge_step();
        int   tail;
        bit   fire, mis;
        @(posedge clk);
        if (rdy) begin
            tail = (m_head + m_count) % D;
            fire = disp_valid && e_disp_ready;
            mis  = e_cm_valid && (m_kind[e_h] == 3 || (m_kind[e_h] == 2 && m_taken[e_h] != m_pred[e_h]));
            m_flush = mis;
            if (mis) m_fpc = (m_kind[e_h] == 3 || m_taken[e_h]) ? m_tgt[e_h] : m_pc[e_h] + 32'd4;
            for (int p = 0; p < NW; p++) begin
                int t;
                t = int'(wb_tag[p*TW +: TW]);
                if (wb_valid[p] && in_window(t)) begin
                    m_ready[t] = 1'b1; m_val[t] = wb_val[p*XL +: XL];
                    m_taken[t] = wb_taken[p]; m_tgt[t] = wb_target[p*XL +: XL];
                end
            end
            if (mis) begin
                m_head = 0; m_count = 0;
            end else begin
                if (e_cm_valid) begin m_head = (m_head + 1) % D; m_count--; end
                if (fire) begin
                    m_ready[tail] = (disp_kind == 2'd1); m_kind[tail] = int'(disp_kind);
                    m_rd[tail] = disp_rd; m_pc[tail] = disp_pc; m_pred[tail] = disp_pred_taken;
                    m_val[tail] = '0; m_taken[tail] = 1'b0; m_tgt[tail] = '0;
                    m_count++;
                end
            end
        end
        #1;
    endtask

    task automatic tick();
        settle();
        edge_step();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_count", count, 0);
        chk("rst_disp_ready", disp_ready, 1);
        chk("rst_flush", flush, 0);
        chk("rst_flush_pc", flush_pc, 0);
        chk("rst_cm_valid", cm_valid, 0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        do_reset();

        // Fill to capacity, then free one slot.
        for (int i = 0; i < D; i++) begin
            idle(); disp(0, i + 1, 32'h1000 + 4 * i, 1'b0); tick();
        end
        idle(); settle();
        chk("full_count", count, D);
        chk("full_disp_ready", disp_ready, 0);
        edge_step();
        idle(); wb(0, 0, 32'h11, 1'b0, 32'h0); settle();
        chk("wb_same_cycle_no_commit", cm_valid, 0);
        edge_step();
        idle(); settle();
        chk("full_commit_valid", cm_valid, 1);
        chk("full_commit_rd", cm_rd, 1);
        chk("full_commit_val", cm_val, 32'h11);
        chk("full_commit_still_blocked", disp_ready, 0);
        edge_step();
        idle(); settle();
        chk("full_reopen", disp_ready, 1);
        edge_step();

        // Out-of-order write-back, in-order commit.
        do_reset();
        for (int i = 0; i < 3; i++) begin idle(); disp(0, 5 + i, 32'h40 + 4 * i, 1'b0); tick(); end
        commit_log.delete();
        idle(); wb(0, 2, 32'd3, 1'b0, 0); tick();
        idle(); wb(1, 1, 32'd2, 1'b0, 0); tick();
        idle(); wb(0, 0, 32'd1, 1'b0, 0); tick();
        for (int i = 0; i < 3; i++) begin idle(); tick(); end
        chk("ooo_commit_count", commit_log.size(), 3);
        for (int i = 0; i < 3 && i < commit_log.size(); i++) chk("ooo_commit_order", commit_log[i], i);

        // Same-cycle bypass on port 1.
        do_reset();
        for (int i = 0; i < 2; i++) begin idle(); disp(0, 9, 32'h80, 1'b0); tick(); end
        idle(); wb(1, 1, 32'hDEAD, 1'b0, 0); q_tag[TW-1:0] = TW'(1); settle();
        chk("bypass_ready", q_ready[0], 1);
        chk("bypass_val", q_val[XL-1:0], 32'hDEAD);
        edge_step();

        // Store held at head by the LSB handshake.
        do_reset();
        idle(); disp(1, 0, 32'h200, 1'b0); tick();
        for (int i = 0; i < 3; i++) begin
            idle(); st_commit_ready = 1'b0; settle();
            chk("store_stall", cm_valid, 0);
            edge_step();
        end
        idle(); settle();
        chk("store_commit", cm_valid, 1);
        chk("store_flag", cm_is_store, 1);
        edge_step();

        // Branch mispredicted taken, then correctly predicted not-taken, then jalr.
        for (int k = 0; k < 3; k++) begin
            do_reset();
            idle(); disp(k == 2 ? 3 : 2, 3, 32'h100, 1'b0); tick();
            idle(); wb(0, 0, 32'h0, k == 0, 32'h80); tick();
            idle(); settle();
            chk("br_commit", cm_valid, 1);
            if (k == 2) chk("jalr_link", cm_val, 32'h104);
            edge_step();
            idle(); settle();
            chk("br_flush", flush, k != 1);
            if (k != 1) begin
                chk("br_flush_pc", flush_pc, 32'h80);
                chk("br_flush_blocks", disp_ready, 0);
            end
            chk("br_count", count, 0);
            edge_step();
            idle(); settle();
            chk("br_reopen", disp_ready, 1);
            edge_step();
        end

        // Tag wrap-around with continuous dispatch/commit.
        do_reset();
        commit_log.delete();
        for (int i = 0; i < 20; i++) begin
            idle(); disp(0, i % 32, 32'h3000 + 4 * i, 1'b0);
            if (i > 0) wb(0, (i - 1) % D, 32'(i), 1'b0, 0);
            settle();
            chk("wrap_tag", disp_tag, i % D);
            edge_step();
        end
        idle(); wb(0, 19 % D, 32'd20, 1'b0, 0); tick();
        for (int i = 0; i < 3; i++) begin idle(); tick(); end
        chk("wrap_commit_count", commit_log.size(), 20);
        for (int i = 0; i < 20 && i < commit_log.size(); i++) chk("wrap_order", commit_log[i], i % D);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            int kr;
            idle();
            rdy = ($urandom_range(0, 9) != 0);
            st_commit_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 7) begin
                kr = $urandom_range(0, 19);
                disp(kr < 13 ? 0 : kr < 16 ? 1 : kr < 19 ? 2 : 3, $urandom_range(0, 31),
                     $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1));
            end
            for (int p = 0; p < NW; p++)
                if ($urandom_range(0, 1) == 1)
                    wb(p, (m_count > 0 && $urandom_range(0, 3) != 0) ?
                          (m_head + $urandom_range(0, m_count - 1)) % D : $urandom_range(0, D - 1),
                       $urandom, $urandom_range(0, 1), $urandom);
            q_tag = 8'($urandom);
            tick();
        end

        // Asynchronous reset mid-operation clears immediately.
        idle(); disp(3, 1, 32'h10, 1'b0); tick();
        idle(); wb(0, m_head, 32'h5, 1'b0, 32'h44); tick();
        @(posedge clk); #3;
        rst = 1'b1; #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_flush", flush, 0);
        chk("async_rst_cm_valid", cm_valid, 0);
        chk("async_rst_disp_ready", disp_ready, 1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
